// File: rtl/load_store_unit_pkg.sv
// Shared encodings and helpers for the load/store unit.
// Holds funct3 codes, FSM state type and access legality check.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_t;

    // Misaligned half/word, reserved funct3, or both classes at once.
    function automatic logic access_bad(
        input logic [2:0] f3,
        input logic [1:0] off,
        input logic       both
    );
        logic ill;
        logic mis;
        ill = both | (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
        mis = ((f3[1:0] == 2'b01) && off[0]) ||
              ((f3[1:0] == 2'b10) && (off != 2'b00));
        return ill | mis;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for the load/store unit.
// Replicates store data, builds strobes, extracts and extends loads.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Store side: replicate the operand across lanes, strobe the target.
    always_comb begin
        wdata = store_data;
        wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << offset;
            end
            2'b01: begin
                wdata = {2{store_data[15:0]}};
                wstrb = 4'b0011 << offset;
            end
            default: begin
                wdata = store_data;
                wstrb = 4'b1111;
            end
        endcase
    end

    // Load side: pick the addressed lane, then sign or zero extend.
    always_comb begin
        lane_b    = rdata[{offset, 3'b000} +: 8];
        lane_h    = offset[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{24{lane_b[7]}}, lane_b};
            F3_LH:   load_data = {{16{lane_h[15]}}, lane_h};
            F3_LBU:  load_data = {24'h0, lane_b};
            F3_LHU:  load_data = {16'h0, lane_h};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one memory access at a time over a req/gnt bus.
// Misaligned or illegal accesses complete at once with err set.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state_q;
    lsu_state_t  state_d;
    logic [31:0] addr_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic [31:0] sdata_q;
    logic        err_q;
    logic [31:0] ldata_q;
    logic        accept;
    logic        bad;
    logic        in_req;
    logic        wr_req;
    logic [31:0] al_wdata;
    logic [3:0]  al_wstrb;
    logic [31:0] al_ldata;

    assign accept = lsu_valid & (is_load | is_store);
    assign bad    = access_bad(funct3, addr[1:0], is_load & is_store);

    lsu_align u_align (
        .funct3     (f3_q),
        .offset     (addr_q[1:0]),
        .store_data (sdata_q),
        .rdata      (mem_rdata),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .load_data  (al_ldata)
    );

    // Next-state: bus handshake sequencing; stray gnt/rvalid ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = bad ? ST_DONE : ST_REQ;
            ST_REQ:  if (mem_gnt) state_d = we_q ? ST_DONE : ST_WAIT;
            ST_WAIT: if (mem_rvalid) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register plus access capture and load result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            sdata_q <= '0;
            err_q   <= 1'b0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && accept) begin
                addr_q  <= addr;
                f3_q    <= funct3;
                we_q    <= is_store & ~is_load;
                sdata_q <= store_data;
                err_q   <= bad;
                ldata_q <= '0;
            end
            if (state_q == ST_WAIT && mem_rvalid) begin
                ldata_q <= al_ldata;
            end
        end
    end

    assign in_req    = (state_q == ST_REQ);
    assign wr_req    = in_req & we_q;
    assign mem_req   = in_req;
    assign mem_we    = wr_req;
    assign mem_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wdata = wr_req ? al_wdata : '0;
    assign mem_wstrb = wr_req ? al_wstrb : '0;
    assign done      = (state_q == ST_DONE);
    assign stall     = accept & (state_q != ST_DONE);
    assign err       = err_q;
    assign load_data = ldata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit.
// Timeline model per access plus literal pins from directed vectors.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .lsu_valid  (lsu_valid),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .load_data  (load_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          chk_en = 1'b0;
    int          cur_k;
    logic        exp_req, exp_done, exp_hold, exp_stall;
    logic        exp_is_load, exp_bad, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic [3:0]  exp_wstrb;

    int          obs_req_cnt;
    int          obs_done_k;
    logic [31:0] obs_addr, obs_wdata, obs_ld;
    logic [3:0]  obs_wstrb;
    logic        obs_err;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic model_bad(input logic ld, input logic st,
                                       input logic [2:0] f3,
                                       input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        if (ld && st) return 1'b1;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        return (off % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3,
                                                input logic [31:0] d);
        if (size_of(f3) == 1) return (d & 32'hFF) * 32'h01010101;
        if (size_of(f3) == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] f3,
                                               input logic [1:0] off);
        int o;
        o = int'(off);
        if (size_of(f3) == 1) return 4'(1 << o);
        if (size_of(f3) == 2) return 4'(3 << o);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3,
                                               input logic [31:0] rd,
                                               input logic [1:0] off);
        logic [31:0] v, mask;
        int sh;
        if (size_of(f3) == 4) return rd;
        if (size_of(f3) == 1) begin
            mask = 32'hFF;
            sh = int'(off) * 8;
        end else begin
            mask = 32'hFFFF;
            sh = (int'(off) / 2) * 16;
        end
        v = (rd >> sh) & mask;
        if (!f3[2] && ((v & (mask ^ (mask >> 1))) != 0)) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk($sformatf("mem_req k%0d", cur_k), 32'(mem_req), 32'(exp_req));
            chk($sformatf("done k%0d", cur_k), 32'(done), 32'(exp_done));
            chk($sformatf("stall k%0d", cur_k), 32'(stall), 32'(exp_stall));
            if (mem_req) begin
                obs_req_cnt++;
                obs_addr  = mem_addr;
                obs_wdata = mem_wdata;
                obs_wstrb = mem_wstrb;
            end
            if (exp_req) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                if (exp_we) begin
                    chk("mem_wdata", mem_wdata, exp_wdata);
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
                end
            end
            if (done) begin
                obs_done_k = cur_k;
                obs_err    = err;
                obs_ld     = load_data;
            end
            if (exp_done || exp_hold) begin
                chk($sformatf("err k%0d", cur_k), 32'(err), 32'(exp_bad));
                if (exp_is_load && !exp_bad)
                    chk($sformatf("load_data k%0d", cur_k), load_data, exp_ld);
            end
        end
    end

    task automatic run(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rd, input int n_req,
                       input int n_wait, input bit noise);
        int done_k;
        logic real_rv;
        exp_bad     = model_bad(ld, st, f3, a);
        exp_is_load = ld && !st;
        exp_we      = st && !ld;
        exp_addr    = a & ~32'h3;
        exp_wdata   = model_wdata(f3, sd);
        exp_wstrb   = model_wstrb(f3, a[1:0]);
        exp_ld      = model_load(f3, rd, a[1:0]);
        if (exp_bad) done_k = 1;
        else if (exp_we) done_k = n_req + 1;
        else done_k = n_req + n_wait + 1;
        obs_req_cnt = 0;
        obs_done_k  = -1;
        obs_err     = 1'bx;
        obs_ld      = 'x;
        for (int k = 0; k <= done_k + 1; k++) begin
            cur_k      = k;
            lsu_valid  = (k <= done_k);
            is_load    = ld;
            is_store   = st;
            funct3     = f3;
            addr       = a;
            store_data = sd;
            exp_req    = !exp_bad && k >= 1 && k <= n_req;
            exp_done   = (k == done_k);
            exp_hold   = (k == done_k + 1);
            exp_stall  = (k < done_k);
            real_rv    = exp_is_load && !exp_bad && (k == n_req + n_wait);
            mem_gnt    = (!exp_bad && k == n_req) ||
                         (noise && (k == 0 || k >= done_k));
            mem_rvalid = real_rv || (noise && (k <= n_req || k >= done_k));
            mem_rdata  = real_rv ? rd : 32'hDEADBEEF;
            chk_en     = 1'b1;
            @(posedge clk);
            #1;
        end
        chk_en     = 1'b0;
        lsu_valid  = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        lsu_valid  = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'b000;
        addr       = '0;
        store_data = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst load_data", load_data, 32'd0);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run(1'b0, 1'b1, 3'b000, 32'h1003, 32'hAABBCCDD, 32'h0, 1, 1, 1'b0);
        chk("sb addr", obs_addr, 32'h1000);
        chk("sb wstrb", 32'(obs_wstrb), 32'h8);
        chk("sb wdata", obs_wdata, 32'hDDDDDDDD);
        chk("sb done cycle", 32'(obs_done_k), 32'd2);
        chk("sb err", 32'(obs_err), 32'd0);

        run(1'b1, 1'b0, 3'b000, 32'h2001, 32'h0, 32'h1234F680, 1, 2, 1'b0);
        chk("lb data", obs_ld, 32'hFFFFFFF6);
        run(1'b1, 1'b0, 3'b100, 32'h2001, 32'h0, 32'h1234F680, 1, 2, 1'b0);
        chk("lbu data", obs_ld, 32'h000000F6);

        run(1'b1, 1'b0, 3'b010, 32'h3002, 32'h0, 32'h0, 1, 1, 1'b0);
        chk("lw mis req", 32'(obs_req_cnt), 32'd0);
        chk("lw mis err", 32'(obs_err), 32'd1);
        chk("lw mis done cycle", 32'(obs_done_k), 32'd1);
        run(1'b1, 1'b0, 3'b011, 32'h3000, 32'h0, 32'h0, 1, 1, 1'b0);
        chk("f3 011 req", 32'(obs_req_cnt), 32'd0);
        chk("f3 011 err", 32'(obs_err), 32'd1);
        chk("f3 011 done cycle", 32'(obs_done_k), 32'd1);

        run(1'b0, 1'b1, 3'b001, 32'h4002, 32'h11223344, 32'h0, 5, 1, 1'b0);
        chk("sh req cycles", 32'(obs_req_cnt), 32'd5);
        chk("sh wstrb", 32'(obs_wstrb), 32'hC);
        chk("sh wdata", obs_wdata, 32'h33443344);
        chk("sh addr", obs_addr, 32'h4000);

        run(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 32'hCAFEF00D, 1, 1, 1'b0);
        chk("lw data", obs_ld, 32'hCAFEF00D);
        chk("lw done cycle", 32'(obs_done_k), 32'd3);
        run(1'b1, 1'b0, 3'b001, 32'h5002, 32'h0, 32'h80011234, 2, 3, 1'b1);
        chk("lh data", obs_ld, 32'hFFFF8001);
        run(1'b1, 1'b0, 3'b101, 32'h5002, 32'h0, 32'h80011234, 1, 1, 1'b1);
        chk("lhu data", obs_ld, 32'h00008001);
        run(1'b1, 1'b0, 3'b000, 32'h5000, 32'h0, 32'h0000007F, 1, 1, 1'b0);
        chk("lb pos data", obs_ld, 32'h0000007F);
        run(1'b0, 1'b1, 3'b010, 32'h6004, 32'h89ABCDEF, 32'h0, 3, 1, 1'b1);
        chk("sw wstrb", 32'(obs_wstrb), 32'hF);
        run(1'b0, 1'b1, 3'b000, 32'h6000, 32'h000000A5, 32'h0, 1, 1, 1'b0);
        chk("sb0 wstrb", 32'(obs_wstrb), 32'h1);
        run(1'b0, 1'b1, 3'b001, 32'h7001, 32'h1234, 32'h0, 1, 1, 1'b0);
        chk("sh mis err", 32'(obs_err), 32'd1);
        run(1'b1, 1'b1, 3'b010, 32'h7000, 32'h0, 32'h0, 1, 1, 1'b0);
        chk("both err", 32'(obs_err), 32'd1);
        run(1'b0, 1'b1, 3'b110, 32'h7000, 32'h0, 32'h0, 1, 1, 1'b0);
        chk("f3 110 err", 32'(obs_err), 32'd1);

        lsu_valid = 1'b1;
        is_load   = 1'b1;
        is_store  = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h2000;
        @(posedge clk);
        #1;
        mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        mem_gnt = 1'b0;
        @(negedge clk);
        chk("wait mem_req", 32'(mem_req), 32'd0);
        chk("wait stall", 32'(stall), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        is_load    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5A5A5A5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post rst mem_req", 32'(mem_req), 32'd0);
            chk("post rst done", 32'(done), 32'd0);
            chk("post rst load_data", load_data, 32'd0);
            chk("post rst stall", 32'(stall), 32'd0);
            @(posedge clk);
            #1;
        end
        mem_rvalid = 1'b0;
        lsu_valid  = 1'b0;

        run(1'b1, 1'b0, 3'b000, 32'h2003, 32'h0, 32'h80FF0000, 1, 1, 1'b0);
        chk("lb after rst", obs_ld, 32'hFFFFFF80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports in the order below.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 lsu_valid  in  1  datapath presents a memory instruction this cycle.
REQ-005 is_load / is_store  in  1 each  instruction class.
REQ-006 funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes illegal.
REQ-007 addr  in  32  byte address, the ALU result.
REQ-008 store_data  in  32  rs2 value.
REQ-009 stall  out  1  hold PC and pipeline registers.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  valid only with done; misaligned or illegal access.
REQ-012 load_data  out  32  formatted load result, valid with done.
REQ-013 mem_req  out  1; mem_we  out  1; mem_addr  out  32 (word-aligned, addr[1:0]=00); mem_wdata  out  32; mem_wstrb  out  4.
REQ-014 mem_gnt  in  1  request accepted; mem_rvalid  in  1  read data valid; mem_rdata  in  32.

Function
REQ-015 SHALL implement the FSM IDLE, REQ, WAIT, DONE.
REQ-016 IDLE: lsu_valid with exactly one of is_load/is_store set SHALL capture addr, funct3, class and store_data, then go to REQ; if the access is misaligned or illegal, it SHALL go directly to DONE with err latched to 1.
REQ-017 Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=00. Illegal: funct3 011/110/111, or is_load and is_store both 1.
REQ-018 REQ: mem_req=1, with mem_addr, mem_we, mem_wdata and mem_wstrb held stable until mem_gnt. Gnt on a store goes to DONE; gnt on a load goes to WAIT.
REQ-019 WAIT: mem_req=0; mem_rvalid SHALL capture the formatted mem_rdata into load_data and go to DONE.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE; load_data and err hold until the next accepted access.
REQ-021 stall = lsu_valid & (is_load | is_store) & ~(state==DONE), combinationally.
REQ-022 Store formatting SHALL be:
- B: wdata={4{data[7:0]}}, wstrb=0001<<addr[1:0].
- H: wdata={2{data[15:0]}}, wstrb=0011<<addr[1:0].
- W: wdata=data, wstrb=1111.
REQ-023 Load formatting SHALL select the byte lane at addr[1:0]*8 (half lane at addr[1]*16), sign-extend for B/H and zero-extend for BU/HU; W passes through.
REQ-024 mem_rvalid outside WAIT and mem_gnt outside REQ SHALL be ignored.
REQ-025 Minimum latency: 3 cycles from acceptance to done (store, gnt in first REQ cycle); 4 cycles for a load with gnt and rvalid immediate. There is no upper bound; the unit waits indefinitely.
REQ-026 lsu_valid low, or neither class set, in IDLE: no state change, stall=0.

Reset
REQ-027 rst SHALL force IDLE from any state, including mid-transaction, with the abandoned access dropped.
REQ-028 After the reset edge: stall=0, done=0, err=0, load_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.

Structure
REQ-029 Shared package SHALL hold the funct3 load/store encodings (LB, LH, LW, LBU, LHU, SB, SH, SW) and the lsu_state_t enum.
REQ-030 One combinational sub-module, lsu_align, SHALL perform store lane replication/strobes and load extraction/extension; the FSM stays in load_store_unit.

Verification
REQ-031 SB, addr=0x1003, store_data=0xAABBCCDD, gnt immediate -> mem_addr=0x1000, wstrb=1000, wdata=0xDDDDDDDD, done 3 cycles after acceptance, err=0.
REQ-032 LB, addr=0x2001, mem_rdata=0x1234F680, rvalid 2 cycles after gnt -> load_data=0xFFFFFFF6; LBU on the same data -> 0x000000F6.
REQ-033 LW, addr=0x3002 -> no mem_req, done with err=1 two cycles after acceptance; funct3=011 -> same response.
REQ-034 SH, addr=0x4002, gnt delayed 5 cycles -> mem_req held 5 cycles with address/data stable, wstrb=1100, stall high until the done cycle.
REQ-035 rst asserted during WAIT, then a late rvalid -> state IDLE, mem_req=0, no done pulse, load_data=0.
